// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences addu/subu/slt/ori/lui/addi/lw/sw/beq/j and drives ALU op plus all datapath controls.
// Optional build macro ADDI_OFLOW_EN: suppresses the register write of an overflowing addi.
module mc_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       oflow,
    output logic [2:0] aluop,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_LUI = 3'b100;

    state_t     state_q;
    state_t     state_d;
    state_t     dec_next_s;
    logic       illegal_s;
    logic       r_legal_s;
    logic [2:0] aluop_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic       ext_op_s;
    logic       pc_wr_s;
    logic [1:0] pc_src_s;
    logic       iord_s;
    logic       mem_wr_s;
    logic       ir_wr_s;
    logic       reg_wr_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       instr_done_s;
    logic       iwb_wr_s;

`ifdef ADDI_OFLOW_EN
    assign iwb_wr_s = ~((opcode == OP_ADDI) & oflow);
`else
    logic unused_oflow_s;
    assign unused_oflow_s = oflow;
    assign iwb_wr_s       = 1'b1;
`endif

    // Instruction decode: dispatch target for the DECODE state and illegal detection
    always_comb begin
        r_legal_s  = (funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_SLT);
        illegal_s  = 1'b0;
        dec_next_s = S_FETCH;
        case (opcode)
            OP_RTYPE: begin
                if (r_legal_s) begin
                    dec_next_s = S_REXEC;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_ADDI, OP_ORI, OP_LUI: dec_next_s = S_IEXEC;
            OP_LW, OP_SW:            dec_next_s = S_MEMADR;
            OP_BEQ:                  dec_next_s = S_BRANCH;
            OP_J:                    dec_next_s = S_JUMP;
            default:                 illegal_s  = 1'b1;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!illegal_s) begin
                    state_d = dec_next_s;
                end else if (ILLEGAL_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_REXEC:  state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode from the current state
    always_comb begin
        aluop_s      = ALU_ADD;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        ext_op_s     = 1'b0;
        pc_wr_s      = 1'b0;
        pc_src_s     = 2'b00;
        iord_s       = 1'b0;
        mem_wr_s     = 1'b0;
        ir_wr_s      = 1'b0;
        reg_wr_s     = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        instr_done_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b_s = 2'b01;
                ir_wr_s     = 1'b1;
                pc_wr_s     = 1'b1;
            end
            S_DECODE: begin
                alu_src_b_s  = 2'b11;
                ext_op_s     = 1'b1;
                instr_done_s = illegal_s & ~ILLEGAL_HALT;
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                ext_op_s    = 1'b1;
            end
            S_MEMRD: iord_s = 1'b1;
            S_MEMWB: begin
                mem_to_reg_s = 1'b1;
                reg_wr_s     = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s       = 1'b1;
                mem_wr_s     = 1'b1;
                instr_done_s = 1'b1;
            end
            S_REXEC: begin
                alu_src_a_s = 1'b1;
                case (funct)
                    FN_SUBU: aluop_s = ALU_SUB;
                    FN_SLT:  aluop_s = ALU_SLT;
                    default: aluop_s = ALU_ADD;
                endcase
            end
            S_RWB: begin
                reg_dst_s    = 1'b1;
                reg_wr_s     = 1'b1;
                instr_done_s = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                case (opcode)
                    OP_ORI:  aluop_s = ALU_OR;
                    OP_LUI:  aluop_s = ALU_LUI;
                    default: ext_op_s = 1'b1;
                endcase
            end
            S_IWB: begin
                reg_wr_s     = iwb_wr_s;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s  = 1'b1;
                aluop_s      = ALU_SUB;
                pc_src_s     = 2'b01;
                pc_wr_s      = zero;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pc_src_s     = 2'b10;
                pc_wr_s      = 1'b1;
                instr_done_s = 1'b1;
            end
            default: begin
                aluop_s = ALU_ADD;
            end
        endcase
    end

    // Reset cycle aborts the instruction: no write enable and all mux selects parked at 0
    assign aluop      = rst ? 3'b000 : aluop_s;
    assign alu_src_a  = alu_src_a_s & ~rst;
    assign alu_src_b  = rst ? 2'b00 : alu_src_b_s;
    assign ext_op     = ext_op_s & ~rst;
    assign pc_wr      = pc_wr_s & ~rst;
    assign pc_src     = rst ? 2'b00 : pc_src_s;
    assign iord       = iord_s & ~rst;
    assign mem_wr     = mem_wr_s & ~rst;
    assign ir_wr      = ir_wr_s & ~rst;
    assign reg_wr     = reg_wr_s & ~rst;
    assign reg_dst    = reg_dst_s & ~rst;
    assign mem_to_reg = mem_to_reg_s & ~rst;
    assign instr_done = instr_done_s & ~rst;
    assign halted     = (state_q == S_HALT);
    assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed table-driven bench for mc_ctrl; a second instance with ILLEGAL_HALT=0 covers the illegal-as-NOP path.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       oflow;

    logic [2:0] aluop, aluop2;
    logic       alu_src_a, alu_src_a2;
    logic [1:0] alu_src_b, alu_src_b2;
    logic       ext_op, ext_op2;
    logic       pc_wr, pc_wr2;
    logic [1:0] pc_src, pc_src2;
    logic       iord, iord2;
    logic       mem_wr, mem_wr2;
    logic       ir_wr, ir_wr2;
    logic       reg_wr, reg_wr2;
    logic       reg_dst, reg_dst2;
    logic       mem_to_reg, mem_to_reg2;
    logic [3:0] state, state2;
    logic       instr_done, instr_done2;
    logic       halted, halted2;

    mc_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .oflow(oflow),
        .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .pc_wr(pc_wr), .pc_src(pc_src), .iord(iord), .mem_wr(mem_wr), .ir_wr(ir_wr),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .instr_done(instr_done), .halted(halted)
    );

    mc_ctrl #(.ILLEGAL_HALT(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .oflow(oflow),
        .aluop(aluop2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .ext_op(ext_op2),
        .pc_wr(pc_wr2), .pc_src(pc_src2), .iord(iord2), .mem_wr(mem_wr2), .ir_wr(ir_wr2),
        .reg_wr(reg_wr2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2), .state(state2),
        .instr_done(instr_done2), .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: {aluop, src_a, src_b, ext, pc_wr, pc_src, iord, mem_wr, ir_wr, reg_wr, reg_dst, m2r, done, halted}
    logic [17:0] out1, out2;
    assign out1 = {aluop, alu_src_a, alu_src_b, ext_op, pc_wr, pc_src, iord, mem_wr, ir_wr,
                   reg_wr, reg_dst, mem_to_reg, instr_done, halted};
    assign out2 = {aluop2, alu_src_a2, alu_src_b2, ext_op2, pc_wr2, pc_src2, iord2, mem_wr2, ir_wr2,
                   reg_wr2, reg_dst2, mem_to_reg2, instr_done2, halted2};

    localparam logic [17:0] E_ZERO   = 18'd0;
    localparam logic [17:0] E_FETCH  = {3'b000, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_DECODE = {3'b000, 1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_DEC_NOP= {3'b000, 1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] E_RX_ADD = {3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_RX_SUB = {3'b011, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_RX_SLT = {3'b010, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_RWB    = {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] E_IX_ADDI= {3'b000, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_IX_ORI = {3'b001, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_IX_LUI = {3'b100, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_IWB    = {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] E_IWB_NW = {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] E_MEMADR = {3'b000, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMRD  = {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMWB  = {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [17:0] E_MEMWR  = {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] E_BR_T   = {3'b011, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] E_BR_NT  = {3'b011, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] E_JUMP   = {3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] E_HALT   = {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ADDI_OFLOW_EN
    localparam logic [17:0] E_IWB_OF = E_IWB_NW;
`else
    localparam logic [17:0] E_IWB_OF = E_IWB;
`endif

    localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101, LUI = 6'b001111;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;
    localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_SLT = 6'b101010, F_0 = 6'b000000;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        oflow;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic of, input logic [3:0] st, input logic [17:0] out);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.zero = z; v.oflow = of; v.st = st; v.out = out;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z, input logic of);
        rst = r; opcode = op; funct = fn; zero = z; oflow = of;
    endtask

    initial begin
        drive(1'b1, BEQ, F_0, 1'b0, 1'b0);
        // reset held two cycles with a beq opcode on the bus
        add(1, BEQ, F_0, 0, 0, 4'd0, E_ZERO);
        add(1, BEQ, F_0, 0, 0, 4'd0, E_ZERO);
        // addu / subu / slt
        add(0, R, F_ADDU, 0, 0, 4'd0, E_FETCH);
        add(0, R, F_ADDU, 0, 0, 4'd1, E_DECODE);
        add(0, R, F_ADDU, 0, 1, 4'd6, E_RX_ADD);
        add(0, R, F_ADDU, 0, 1, 4'd7, E_RWB);
        add(0, R, F_SUBU, 0, 0, 4'd0, E_FETCH);
        add(0, R, F_SUBU, 0, 0, 4'd1, E_DECODE);
        add(0, R, F_SUBU, 0, 0, 4'd6, E_RX_SUB);
        add(0, R, F_SUBU, 0, 0, 4'd7, E_RWB);
        add(0, R, F_SLT,  1, 0, 4'd0, E_FETCH);
        add(0, R, F_SLT,  1, 0, 4'd1, E_DECODE);
        add(0, R, F_SLT,  1, 0, 4'd6, E_RX_SLT);
        add(0, R, F_SLT,  1, 0, 4'd7, E_RWB);
        // lw (5 cycles) and sw (4 cycles)
        add(0, LW, F_0, 0, 0, 4'd0, E_FETCH);
        add(0, LW, F_0, 0, 0, 4'd1, E_DECODE);
        add(0, LW, F_0, 0, 0, 4'd2, E_MEMADR);
        add(0, LW, F_0, 0, 0, 4'd3, E_MEMRD);
        add(0, LW, F_0, 0, 0, 4'd4, E_MEMWB);
        add(0, SW, F_0, 0, 0, 4'd0, E_FETCH);
        add(0, SW, F_0, 0, 0, 4'd1, E_DECODE);
        add(0, SW, F_0, 0, 0, 4'd2, E_MEMADR);
        add(0, SW, F_0, 0, 0, 4'd5, E_MEMWR);
        // beq taken / not taken, j
        add(0, BEQ, F_0, 0, 0, 4'd0, E_FETCH);
        add(0, BEQ, F_0, 0, 0, 4'd1, E_DECODE);
        add(0, BEQ, F_0, 1, 0, 4'd10, E_BR_T);
        add(0, BEQ, F_0, 1, 0, 4'd0, E_FETCH);
        add(0, BEQ, F_0, 1, 0, 4'd1, E_DECODE);
        add(0, BEQ, F_0, 0, 0, 4'd10, E_BR_NT);
        add(0, JMP, F_0, 0, 0, 4'd0, E_FETCH);
        add(0, JMP, F_0, 0, 0, 4'd1, E_DECODE);
        add(0, JMP, F_0, 0, 0, 4'd11, E_JUMP);
        // ori (oflow high must not block it), lui, addi with overflow
        add(0, ORI, F_0, 0, 1, 4'd0, E_FETCH);
        add(0, ORI, F_0, 0, 1, 4'd1, E_DECODE);
        add(0, ORI, F_0, 0, 1, 4'd8, E_IX_ORI);
        add(0, ORI, F_0, 0, 1, 4'd9, E_IWB);
        add(0, LUI, F_0, 0, 0, 4'd0, E_FETCH);
        add(0, LUI, F_0, 0, 0, 4'd1, E_DECODE);
        add(0, LUI, F_0, 0, 0, 4'd8, E_IX_LUI);
        add(0, LUI, F_0, 0, 0, 4'd9, E_IWB);
        add(0, ADDI, F_0, 0, 1, 4'd0, E_FETCH);
        add(0, ADDI, F_0, 0, 1, 4'd1, E_DECODE);
        add(0, ADDI, F_0, 0, 1, 4'd8, E_IX_ADDI);
        add(0, ADDI, F_0, 0, 1, 4'd9, E_IWB_OF);
        add(0, ADDI, F_0, 0, 0, 4'd0, E_FETCH);
        add(0, ADDI, F_0, 0, 0, 4'd1, E_DECODE);
        add(0, ADDI, F_0, 0, 0, 4'd8, E_IX_ADDI);
        add(0, ADDI, F_0, 0, 0, 4'd9, E_IWB);
        // reset mid-lw (in MEMRD) and mid-sw (in MEMWR) and in DECODE
        add(0, LW, F_0, 0, 0, 4'd0, E_FETCH);
        add(0, LW, F_0, 0, 0, 4'd1, E_DECODE);
        add(0, LW, F_0, 0, 0, 4'd2, E_MEMADR);
        add(1, LW, F_0, 0, 0, 4'd3, E_ZERO);
        add(0, SW, F_0, 0, 0, 4'd0, E_FETCH);
        add(0, SW, F_0, 0, 0, 4'd1, E_DECODE);
        add(0, SW, F_0, 0, 0, 4'd2, E_MEMADR);
        add(1, SW, F_0, 0, 0, 4'd5, E_ZERO);
        add(0, SW, F_0, 0, 0, 4'd0, E_FETCH);
        add(1, SW, F_0, 0, 0, 4'd1, E_ZERO);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].zero, vecs[i].oflow);
            @(negedge clk);
            check($sformatf("vec%0d.state", i), {28'd0, state}, {28'd0, vecs[i].st});
            check($sformatf("vec%0d.outs", i), {14'd0, out1}, {14'd0, vecs[i].out});
            @(posedge clk);
            #1;
        end

        // illegal opcode: halting instance goes to HALT, NOP instance retires in DECODE
        drive(1'b0, BAD, F_0, 1'b0, 1'b0);
        @(negedge clk);
        check("ill.fetch.state", {28'd0, state}, 32'd0);
        check("ill.fetch.state_nop", {28'd0, state2}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ill.decode.outs", {14'd0, out1}, {14'd0, E_DECODE});
        check("ill.decode.outs_nop", {14'd0, out2}, {14'd0, E_DEC_NOP});
        @(posedge clk); #1;
        drive(1'b0, LW, F_0, 1'b1, 1'b1);
        @(negedge clk);
        check("ill.nop.state", {28'd0, state2}, 32'd0);
        check("ill.nop.outs", {14'd0, out2}, {14'd0, E_FETCH});
        for (int c = 0; c < 3; c++) begin
            check($sformatf("halt%0d.state", c), {28'd0, state}, 32'd15);
            check($sformatf("halt%0d.outs", c), {14'd0, out1}, {14'd0, E_HALT});
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        drive(1'b1, LW, F_0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, R, F_0, 1'b0, 1'b0);
        @(negedge clk);
        check("halt.rst.state", {28'd0, state}, 32'd0);
        check("halt.rst.outs", {14'd0, out1}, {14'd0, E_FETCH});
        // R-type with unknown funct is also illegal
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("badfn.state", {28'd0, state}, 32'd15);
        check("badfn.state_nop", {28'd0, state2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
